// File: rtl/input_data_fetcher_if.sv
// Input-feature buffer read bus between the fetcher (master) and the buffer (slave).
interface input_data_fetcher_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_radd;
  logic                  mem_rden;
  logic [DATA_WIDTH-1:0] mem_rdat;
  logic                  mem_rvld;

  modport master (output mem_radd, output mem_rden, input  mem_rdat, input  mem_rvld);
  modport slave  (input  mem_radd, input  mem_rden, output mem_rdat, output mem_rvld);
endinterface

// File: rtl/input_data_fetcher.sv
// Turns core pixel requests into in-order input-buffer reads, re-reading the map once per
// kernel group, and returns the pixel words to the core.
module input_data_fetcher #(
  parameter int unsigned BIT_WIDTH    = 8,
  parameter int unsigned NUM_CHANNEL  = 3,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_WIDTH    = 32,
  parameter int unsigned MAX_OUTSTAND = 4,
  parameter int unsigned PEND_WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_data_req,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0] o_data,
  output logic                             o_data_vld,
  input_data_fetcher_if.master             mem,
  input  logic [REG_WIDTH-1:0]             i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]             i_conf_base,
  input  logic [REG_WIDTH-1:0]             i_conf_nwords,
  input  logic [REG_WIDTH-1:0]             i_conf_npass,
  output logic                             o_done,
  output logic [2:0]                       o_err
);

  localparam int unsigned PIX_W = BIT_WIDTH * NUM_CHANNEL;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTAND) + 1;
  localparam logic [OUT_W-1:0]      OUT_MAX  = OUT_W'(MAX_OUTSTAND);
  localparam logic [PEND_WIDTH-1:0] PEND_SAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [REG_WIDTH-1:0]  idx;
  logic [REG_WIDTH-1:0]  pass;
  logic [PEND_WIDTH-1:0] pending;
  logic [OUT_W-1:0]      outstand;

  logic enable;
  logic req_run;
  logic req_acc;
  logic issue;
  logic last_word;
  logic rsp_ok;
  logic rsp_deliver;
  logic stray;
  logic unused_bits;

  assign unused_bits = ^{i_conf_ctrl, mem.mem_rdat};

  // A request can be served in the same cycle it arrives, so issue looks past pending.
  always_comb begin
    enable      = i_conf_ctrl[0];
    req_run     = i_data_req && (state == RUN);
    req_acc     = req_run && (pending != PEND_SAT);
    issue       = enable && (state == RUN) && ((pending != '0) || req_acc) &&
                  (outstand < OUT_MAX) && (pass < i_conf_npass);
    last_word   = (idx == (i_conf_nwords - REG_WIDTH'(1)));
    rsp_ok      = mem.mem_rvld && (outstand != '0);
    rsp_deliver = rsp_ok && ((state == RUN) || (state == DRAIN));
    stray       = mem.mem_rvld && (outstand == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_done    = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = RUN;
        RUN:   if ((pass == i_conf_npass) && (pending == '0)) state_nxt = DRAIN;
        DRAIN: if (outstand == '0) state_nxt = DONE;
        DONE:  state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
    if (state == DONE) o_done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      pass       <= '0;
      pending    <= '0;
      outstand   <= '0;
      mem.mem_rden <= 1'b0;
      mem.mem_radd <= '0;
      o_data_vld <= 1'b0;
      o_data     <= '0;
      o_err      <= '0;
    end else begin
      mem.mem_rden <= issue;
      if (issue) mem.mem_radd <= ADDR_WIDTH'(i_conf_base) + ADDR_WIDTH'(idx);

      // IDLE (including the entry cycle into RUN) and any abort hold the walk at its origin.
      if (!enable || (state == IDLE)) begin
        idx     <= '0;
        pass    <= '0;
        pending <= '0;
      end else if (state == RUN) begin
        if (issue) begin
          if (last_word) begin
            idx  <= '0;
            pass <= pass + REG_WIDTH'(1);
          end else begin
            idx <= idx + REG_WIDTH'(1);
          end
        end
        case ({req_acc, issue})
          2'b10:   pending <= pending + PEND_WIDTH'(1);
          2'b01:   pending <= pending - PEND_WIDTH'(1);
          default: pending <= pending;
        endcase
      end

      // Keeps counting returns after an abort so late responses are still accounted for.
      case ({issue, rsp_ok})
        2'b10:   outstand <= outstand + OUT_W'(1);
        2'b01:   outstand <= outstand - OUT_W'(1);
        default: outstand <= outstand;
      endcase

      o_data_vld <= rsp_deliver;
      if (rsp_deliver) o_data <= mem.mem_rdat[PIX_W-1:0];

      if ((state == IDLE) && enable) begin
        o_err <= '0;
      end else begin
        if (i_data_req && (state != RUN))      o_err[0] <= 1'b1;
        if (stray)                             o_err[1] <= 1'b1;
        if (req_run && (pending == PEND_SAT))  o_err[2] <= 1'b1;
      end
    end
  end

endmodule
